// File: rtl/data_check_if.sv
// rtl/data_check_if.sv - Aurora RX AXI4-Stream beat bundle (no tready; every valid beat is consumed)
interface data_check_if;
    logic         tvalid;
    logic [255:0] tdata;
    logic [31:0]  tkeep;
    logic         tlast;

    modport master (output tvalid, output tdata, output tkeep, output tlast);
    modport slave  (input  tvalid, input  tdata, input  tkeep, input  tlast);
endinterface

// File: rtl/data_check.sv
// rtl/data_check.sv - RX pattern checker: incrementing {8{seq}} data, frame length and tkeep
module data_check #(
    parameter int FRAME_BEATS = 16,
    parameter int LOCK_BEATS  = 4
) (
    input  logic         axis_aclk,
    input  logic         axis_areset,
    input  logic         clear_cnt,
    data_check_if.slave  axis,
    output logic         locked,
    output logic         err_sticky,
    output logic [31:0]  beat_cnt,
    output logic [31:0]  frame_cnt,
    output logic [31:0]  data_err_cnt,
    output logic [15:0]  fmt_err_cnt,
    output logic [31:0]  first_err_data
);
    typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;

    localparam logic [15:0] LAST_IDX = 16'(FRAME_BEATS - 1);
    localparam logic [15:0] LOCK_N   = 16'(LOCK_BEATS);

    state_t      state, state_nxt;
    logic [31:0] exp_seq, exp_nxt;
    logic [15:0] good_run, good_nxt;
    logic [1:0]  bad_run, bad_nxt;
    logic [15:0] beat_idx;

    logic [31:0] word0;
    logic        all_equal, good_beat, data_err, keep_err, len_err, any_err;
    logic [1:0]  fmt_inc;
    logic [16:0] fmt_sum;

    assign word0 = axis.tdata[31:0];

    always_comb begin
        all_equal = 1'b1;
        for (int i = 1; i < 8; i++) begin
            if (axis.tdata[i*32 +: 32] != word0) all_equal = 1'b0;
        end
    end

    assign good_beat = all_equal && (word0 == exp_seq);

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_seq;
        good_nxt  = good_run;
        bad_nxt   = bad_run;
        data_err  = 1'b0;
        if (axis.tvalid) begin
            case (state)
                HUNT: begin
                    if (all_equal) begin
                        exp_nxt   = word0 + 32'd1;
                        good_nxt  = 16'd1;
                        bad_nxt   = 2'd0;
                        state_nxt = ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (good_beat) begin
                        exp_nxt = exp_seq + 32'd1;
                        if (good_run < LOCK_N) good_nxt = good_run + 16'd1;
                        if (good_run + 16'd1 >= LOCK_N) state_nxt = LOCKED;
                    end else begin
                        exp_nxt  = word0 + 32'd1;
                        good_nxt = 16'd1;
                    end
                end
                LOCKED: begin
                    if (good_beat) begin
                        exp_nxt = exp_seq + 32'd1;
                        bad_nxt = 2'd0;
                    end else begin
                        data_err = 1'b1;
                        exp_nxt  = word0 + 32'd1;
                        // Fourth consecutive miss: the stream is gone, start hunting again
                        if (bad_run == 2'd3) begin
                            state_nxt = HUNT;
                            bad_nxt   = 2'd0;
                            good_nxt  = 16'd0;
                        end else begin
                            bad_nxt = bad_run + 2'd1;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    assign keep_err = axis.tvalid && (state == LOCKED) && (axis.tkeep != '1);
    assign len_err  = axis.tvalid && (state == LOCKED) &&
                      ((axis.tlast && (beat_idx != LAST_IDX)) ||
                       (!axis.tlast && (beat_idx == LAST_IDX)));
    assign fmt_inc  = {1'b0, keep_err} + {1'b0, len_err};
    assign fmt_sum  = {1'b0, fmt_err_cnt} + {15'd0, fmt_inc};
    assign any_err  = data_err || keep_err || len_err;
    assign locked   = (state == LOCKED);

    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state          <= HUNT;
            exp_seq        <= '0;
            good_run       <= '0;
            bad_run        <= '0;
            beat_idx       <= '0;
            err_sticky     <= 1'b0;
            beat_cnt       <= '0;
            frame_cnt      <= '0;
            data_err_cnt   <= '0;
            fmt_err_cnt    <= '0;
            first_err_data <= '0;
        end else begin
            state    <= state_nxt;
            exp_seq  <= exp_nxt;
            good_run <= good_nxt;
            bad_run  <= bad_nxt;
            if (axis.tvalid) begin
                beat_idx <= (axis.tlast || beat_idx == LAST_IDX) ? 16'd0 : beat_idx + 16'd1;
            end
            // Clear wins over this cycle's counts, but the FSM above still tracks the beat
            if (clear_cnt) begin
                err_sticky     <= 1'b0;
                beat_cnt       <= '0;
                frame_cnt      <= '0;
                data_err_cnt   <= '0;
                fmt_err_cnt    <= '0;
                first_err_data <= '0;
            end else begin
                if (axis.tvalid && beat_cnt != '1) beat_cnt <= beat_cnt + 32'd1;
                if (axis.tvalid && axis.tlast && frame_cnt != '1) frame_cnt <= frame_cnt + 32'd1;
                if (data_err && data_err_cnt != '1) data_err_cnt <= data_err_cnt + 32'd1;
                fmt_err_cnt <= fmt_sum[16] ? 16'hFFFF : fmt_sum[15:0];
                if (any_err) begin
                    err_sticky <= 1'b1;
                    if (!err_sticky) first_err_data <= word0;
                end
            end
        end
    end
endmodule
